snake_step_ctrl: RTL and testbench

Per-move controller upstream of the snake body shift registers and the draw/erase FSM. The draw FSM raises one step request after erasing the snake. This block latches the player direction and computes the next head cell. It then checks walls, self-collision and the apple, and issues exactly one shift or grow command. Body coordinates are read one segment per cycle over a small indexed lookup port.

---
 rtl/snake_pkg.sv | 33 +++
 rtl/snake_dir_latch.sv | 44 ++++
 rtl/snake_step_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_snake_step_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared constants and types for the snake step controller.
//   - direction encoding (matches the key bit order on key_n)
//   - default screen/cell/length parameters
//   - step FSM state encoding
//   - dir_reverse(): the opposite direction of a given direction
package snake_pkg;

    localparam int DEF_XSCREEN = 160;
    localparam int DEF_YSCREEN = 120;
    localparam int DEF_CELL    = 10;
    localparam int DEF_MAX_LEN = 4;
    localparam int DEF_LEN_W   = 4;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_SCAN   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DIE    = 3'd4,
        ST_DEAD   = 3'd5
    } state_t;

    // Right<->left and down<->up are bitwise complements in this encoding.
    function automatic logic [1:0] dir_reverse(input logic [1:0] d);
        return d ^ 2'b11;
    endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// snake_dir_latch: direction register fed by the raw player keys.
//   clk      in   system clock
//   reset    in   synchronous active-high reset (dir -> up)
//   key_n    in   active-low keys [0] right [1] down [2] up [3] left
//   cur_len  in   current snake length; reversal is rejected when > 1
//   dir      out  latched direction
// Only the highest-priority pressed key is considered; if that key is a
// reversal it is dropped rather than falling through to a lower key.
module snake_dir_latch
    import snake_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_n,
    input  logic [LEN_W-1:0] cur_len,
    output logic [1:0]       dir
);

    logic       key_valid;
    logic [1:0] key_dir;
    logic       reject;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = DIR_UP;
        if (!key_n[0])      key_dir = DIR_RIGHT;
        else if (!key_n[1]) key_dir = DIR_DOWN;
        else if (!key_n[2]) key_dir = DIR_UP;
        else if (!key_n[3]) key_dir = DIR_LEFT;
        else                key_valid = 1'b0;
    end

    assign reject = (cur_len > LEN_W'(1)) && (key_dir == dir_reverse(dir));

    always_ff @(posedge clk) begin
        if (reset)
            dir <= DIR_UP;
        else if (key_valid && !reject)
            dir <= key_dir;
    end

endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: per-move controller for the snake game.
// On a step request it computes the next head cell from the latched
// direction, checks walls, scans the body for self-collision one segment
// per cycle, and issues exactly one shift_en or grow pulse (or dies).
//   clk, reset            system clock, synchronous active-high reset
//   key_n                 raw active-low keys (see snake_dir_latch)
//   step                  one-cycle move request
//   cur_len               current length 1..MAX_LEN
//   head_x/head_y         current head pixel position
//   seg_idx/seg_x/seg_y   indexed body read port (seg_x/y combinational)
//   apple_x/apple_y       apple position
//   next_x/next_y         computed next head, held until the next step
//   shift_en/grow/eaten   one-cycle result pulses
//   dead                  sticky game-over
//   busy/done             step in progress / step finished pulse
//   dir                   latched direction
// Build option: define SNAKE_WRAP_EN to wrap around screen edges instead
// of dying on them.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for step
// ST_CALC   | compute next head, wall check, pick last scan index
// ST_SCAN   | compare one body segment per cycle against next head
// ST_COMMIT | pulse done and shift_en/grow/eaten
// ST_DIE    | collision: pulse done, dead asserted
// ST_DEAD   | game over, held until reset
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int XSCREEN = DEF_XSCREEN,
    parameter int YSCREEN = DEF_YSCREEN,
    parameter int CELL    = DEF_CELL,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_n,
    input  logic             step,
    input  logic [LEN_W-1:0] cur_len,
    input  logic [7:0]       head_x,
    input  logic [6:0]       head_y,
    output logic [LEN_W-1:0] seg_idx,
    input  logic [7:0]       seg_x,
    input  logic [6:0]       seg_y,
    input  logic [7:0]       apple_x,
    input  logic [6:0]       apple_y,
    output logic [7:0]       next_x,
    output logic [6:0]       next_y,
    output logic             shift_en,
    output logic             grow,
    output logic             eaten,
    output logic             dead,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dir
);

    localparam logic [7:0]       CELL_X  = 8'(CELL);
    localparam logic [6:0]       CELL_Y  = 7'(CELL);
    localparam logic [7:0]       X_LAST  = 8'(XSCREEN - CELL);
    localparam logic [6:0]       Y_LAST  = 7'(YSCREEN - CELL);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t           state, state_nxt;
    logic [7:0]       calc_x;
    logic [6:0]       calc_y;
    logic             wall_hit;
    logic             calc_apple;
    logic [LEN_W-1:0] calc_last;
    logic             apple_hit;
    logic [LEN_W-1:0] last_idx;
    logic             seg_hit;

    snake_dir_latch #(.LEN_W(LEN_W)) u_dir_latch (
        .clk     (clk),
        .reset   (reset),
        .key_n   (key_n),
        .cur_len (cur_len),
        .dir     (dir)
    );

    // Edge test comes first so the subtraction never sees a zero coordinate.
    always_comb begin
        calc_x   = head_x;
        calc_y   = head_y;
        wall_hit = 1'b0;
        unique case (dir)
            DIR_RIGHT: begin
                if (head_x == X_LAST) begin
`ifdef SNAKE_WRAP_EN
                    calc_x = 8'd0;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    calc_x = head_x + CELL_X;
                end
            end
            DIR_LEFT: begin
                if (head_x == 8'd0) begin
`ifdef SNAKE_WRAP_EN
                    calc_x = X_LAST;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    calc_x = head_x - CELL_X;
                end
            end
            DIR_DOWN: begin
                if (head_y == Y_LAST) begin
`ifdef SNAKE_WRAP_EN
                    calc_y = 7'd0;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    calc_y = head_y + CELL_Y;
                end
            end
            DIR_UP: begin
                if (head_y == 7'd0) begin
`ifdef SNAKE_WRAP_EN
                    calc_y = Y_LAST;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    calc_y = head_y - CELL_Y;
                end
            end
        endcase
    end

    // The tail only stays in place when the snake grows, so it only needs
    // checking when the apple is hit.
    assign calc_apple = (calc_x == apple_x) && (calc_y == apple_y);
    assign calc_last  = calc_apple ? (cur_len - LEN_W'(1)) : (cur_len - LEN_W'(2));
    assign seg_hit    = (seg_x == next_x) && (seg_y == next_y);

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        grow      = 1'b0;
        eaten     = 1'b0;
        dead      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (step)
                    state_nxt = ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (wall_hit)
                    state_nxt = ST_DIE;
                else if (!calc_apple && (cur_len == LEN_W'(1)))
                    state_nxt = ST_COMMIT;
                else
                    state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (seg_hit)
                    state_nxt = ST_DIE;
                else if (seg_idx == last_idx)
                    state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                busy      = 1'b1;
                done      = 1'b1;
                eaten     = apple_hit;
                grow      = apple_hit && (cur_len < LEN_MAX);
                shift_en  = !apple_hit || (cur_len >= LEN_MAX);
                state_nxt = ST_IDLE;
            end
            ST_DIE: begin
                busy      = 1'b1;
                done      = 1'b1;
                dead      = 1'b1;
                state_nxt = ST_DEAD;
            end
            ST_DEAD: begin
                dead = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_x    <= 8'd0;
            next_y    <= 7'd0;
            seg_idx   <= '0;
            apple_hit <= 1'b0;
            last_idx  <= '0;
        end else begin
            if (state == ST_CALC && !wall_hit) begin
                next_x    <= calc_x;
                next_y    <= calc_y;
                apple_hit <= calc_apple;
                last_idx  <= calc_last;
                seg_idx   <= '0;
            end else if (state == ST_SCAN && state_nxt == ST_SCAN) begin
                seg_idx <= seg_idx + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_snake_step_ctrl.sv
module tb_snake_step_ctrl;
    localparam int LEN_W = 4;

    logic             clk;
    logic             reset;
    logic [3:0]       key_n;
    logic             step;
    logic [LEN_W-1:0] cur_len;
    logic [7:0]       head_x;
    logic [6:0]       head_y;
    logic [LEN_W-1:0] seg_idx;
    logic [7:0]       seg_x;
    logic [6:0]       seg_y;
    logic [7:0]       apple_x;
    logic [6:0]       apple_y;
    logic [7:0]       next_x;
    logic [6:0]       next_y;
    logic             shift_en, grow, eaten, dead, busy, done;
    logic [1:0]       dir;

    logic [0:3][7:0]  body_x;
    logic [0:3][6:0]  body_y;

    int checks   = 0;
    int failures = 0;

    snake_step_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .step     (step),
        .cur_len  (cur_len),
        .head_x   (head_x),
        .head_y   (head_y),
        .seg_idx  (seg_idx),
        .seg_x    (seg_x),
        .seg_y    (seg_y),
        .apple_x  (apple_x),
        .apple_y  (apple_y),
        .next_x   (next_x),
        .next_y   (next_y),
        .shift_en (shift_en),
        .grow     (grow),
        .eaten    (eaten),
        .dead     (dead),
        .busy     (busy),
        .done     (done),
        .dir      (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Body memory model: combinational read by segment index.
    always_comb begin
        seg_x = 8'd0;
        seg_y = 7'd0;
        if (seg_idx < LEN_W'(4)) begin
            seg_x = body_x[seg_idx[1:0]];
            seg_y = body_y[seg_idx[1:0]];
        end
    end

    typedef struct {
        bit              rst;
        logic [3:0]      key;
        int              len;
        int              hx, hy;
        logic [0:3][7:0] bx;
        logic [0:3][6:0] by;
        int              ax, ay;
        bit              chk_next;
        int              nx, ny;
        int              shift, grow, eaten, dead;
        int              lat;
        int              dir;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step  = 1'b0;
        key_n = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        key_n   = v.key;
        cur_len = LEN_W'(v.len);
        head_x  = 8'(v.hx);
        head_y  = 7'(v.hy);
        body_x  = v.bx;
        body_y  = v.by;
        apple_x = 8'(v.ax);
        apple_y = 7'(v.ay);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int n_shift, n_grow, n_eaten, n_done, lat;
        bit found;
        n_shift = 0; n_grow = 0; n_eaten = 0; n_done = 0; lat = 0; found = 0;
        if (v.rst) do_reset();
        drive(v);
        @(negedge clk);
        key_n = 4'hF;
        step  = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk($sformatf("v%0d_busy_calc", i), int'(busy), 1);
        for (int c = 1; c <= 20 && !found; c++) begin
            n_shift += int'(shift_en);
            n_grow  += int'(grow);
            n_eaten += int'(eaten);
            n_done  += int'(done);
            if (done) begin
                found = 1;
                lat   = c;
            end
            @(negedge clk);
        end
        // one cycle past done: nothing further may pulse
        n_shift += int'(shift_en);
        n_grow  += int'(grow);
        n_eaten += int'(eaten);
        n_done  += int'(done);
        chk($sformatf("v%0d_latency", i), lat, v.lat);
        chk($sformatf("v%0d_done_cnt", i), n_done, 1);
        chk($sformatf("v%0d_shift_cnt", i), n_shift, v.shift);
        chk($sformatf("v%0d_grow_cnt", i), n_grow, v.grow);
        chk($sformatf("v%0d_eaten_cnt", i), n_eaten, v.eaten);
        chk($sformatf("v%0d_dead", i), int'(dead), v.dead);
        chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
        chk($sformatf("v%0d_dir", i), int'(dir), v.dir);
        if (v.chk_next) begin
            chk($sformatf("v%0d_next_x", i), int'(next_x), v.nx);
            chk($sformatf("v%0d_next_y", i), int'(next_y), v.ny);
        end
    endtask

    initial begin
        vec_t v;
        int   n_busy, n_done, n_pulse;

        // straight up from (80,60), len 4, tail vacates: 3 segments scanned
        vecs[0] = '{rst:1, key:4'hF, len:4, hx:80, hy:60,
                    bx:{8'd80, 8'd80, 8'd80, 8'd80}, by:{7'd60, 7'd70, 7'd80, 7'd90},
                    ax:150, ay:110, chk_next:1, nx:80, ny:50,
                    shift:1, grow:0, eaten:0, dead:0, lat:5, dir:2};
        // turn left
        vecs[1] = '{rst:0, key:4'b0111, len:4, hx:80, hy:60,
                    bx:{8'd80, 8'd80, 8'd80, 8'd80}, by:{7'd60, 7'd70, 7'd80, 7'd90},
                    ax:150, ay:110, chk_next:1, nx:70, ny:60,
                    shift:1, grow:0, eaten:0, dead:0, lat:5, dir:3};
        // right is a reversal with len>1: ignored
        vecs[2] = '{rst:0, key:4'b1110, len:4, hx:80, hy:60,
                    bx:{8'd80, 8'd80, 8'd80, 8'd80}, by:{7'd60, 7'd70, 7'd80, 7'd90},
                    ax:150, ay:110, chk_next:1, nx:70, ny:60,
                    shift:1, grow:0, eaten:0, dead:0, lat:5, dir:3};
        // up into apple, len 3: grow, full 3-segment scan
        vecs[3] = '{rst:0, key:4'b1011, len:3, hx:80, hy:40,
                    bx:{8'd80, 8'd80, 8'd80, 8'd0}, by:{7'd40, 7'd50, 7'd60, 7'd0},
                    ax:80, ay:30, chk_next:1, nx:80, ny:30,
                    shift:0, grow:1, eaten:1, dead:0, lat:5, dir:2};
        // apple at max length: eaten + shift, 4 segments scanned
        vecs[4] = '{rst:0, key:4'hF, len:4, hx:80, hy:40,
                    bx:{8'd80, 8'd80, 8'd80, 8'd80}, by:{7'd40, 7'd50, 7'd60, 7'd70},
                    ax:80, ay:30, chk_next:1, nx:80, ny:30,
                    shift:1, grow:0, eaten:1, dead:0, lat:6, dir:2};
        // len 1, no apple: scan skipped
        vecs[5] = '{rst:0, key:4'hF, len:1, hx:80, hy:40,
                    bx:{8'd80, 8'd0, 8'd0, 8'd0}, by:{7'd40, 7'd0, 7'd0, 7'd0},
                    ax:150, ay:110, chk_next:1, nx:80, ny:30,
                    shift:1, grow:0, eaten:0, dead:0, lat:2, dir:2};
        // len 1 with apple: one segment scanned, grow
        vecs[6] = '{rst:0, key:4'hF, len:1, hx:80, hy:40,
                    bx:{8'd80, 8'd0, 8'd0, 8'd0}, by:{7'd40, 7'd0, 7'd0, 7'd0},
                    ax:80, ay:30, chk_next:1, nx:80, ny:30,
                    shift:0, grow:1, eaten:1, dead:0, lat:3, dir:2};
        // len 1 may reverse: up -> down
        vecs[7] = '{rst:0, key:4'b1101, len:1, hx:80, hy:40,
                    bx:{8'd80, 8'd0, 8'd0, 8'd0}, by:{7'd40, 7'd0, 7'd0, 7'd0},
                    ax:150, ay:110, chk_next:1, nx:80, ny:50,
                    shift:1, grow:0, eaten:0, dead:0, lat:2, dir:1};
        // all keys pressed: right wins
        vecs[8] = '{rst:0, key:4'b0000, len:2, hx:80, hy:40,
                    bx:{8'd80, 8'd70, 8'd0, 8'd0}, by:{7'd40, 7'd40, 7'd0, 7'd0},
                    ax:150, ay:110, chk_next:1, nx:90, ny:40,
                    shift:1, grow:0, eaten:0, dead:0, lat:3, dir:0};
        // down onto the vacating tail: legal
        vecs[9] = '{rst:0, key:4'b1101, len:4, hx:80, hy:60,
                    bx:{8'd80, 8'd90, 8'd90, 8'd80}, by:{7'd60, 7'd60, 7'd70, 7'd70},
                    ax:150, ay:110, chk_next:1, nx:80, ny:70,
                    shift:1, grow:0, eaten:0, dead:0, lat:5, dir:1};
        // same, apple on the tail: tail stays, collision at idx 3
        vecs[10] = '{rst:0, key:4'hF, len:4, hx:80, hy:60,
                     bx:{8'd80, 8'd90, 8'd90, 8'd80}, by:{7'd60, 7'd60, 7'd70, 7'd70},
                     ax:80, ay:70, chk_next:1, nx:80, ny:70,
                     shift:0, grow:0, eaten:0, dead:1, lat:6, dir:1};
`ifdef SNAKE_WRAP_EN
        vecs[11] = '{rst:1, key:4'hF, len:4, hx:80, hy:0,
                     bx:{8'd80, 8'd80, 8'd80, 8'd80}, by:{7'd0, 7'd10, 7'd20, 7'd30},
                     ax:150, ay:110, chk_next:1, nx:80, ny:110,
                     shift:1, grow:0, eaten:0, dead:0, lat:5, dir:2};
        vecs[12] = '{rst:1, key:4'b1110, len:1, hx:150, hy:60,
                     bx:{8'd150, 8'd0, 8'd0, 8'd0}, by:{7'd60, 7'd0, 7'd0, 7'd0},
                     ax:150, ay:110, chk_next:1, nx:0, ny:60,
                     shift:1, grow:0, eaten:0, dead:0, lat:2, dir:0};
`else
        vecs[11] = '{rst:1, key:4'hF, len:4, hx:80, hy:0,
                     bx:{8'd80, 8'd80, 8'd80, 8'd80}, by:{7'd0, 7'd10, 7'd20, 7'd30},
                     ax:150, ay:110, chk_next:0, nx:0, ny:0,
                     shift:0, grow:0, eaten:0, dead:1, lat:2, dir:2};
        vecs[12] = '{rst:1, key:4'b1110, len:1, hx:150, hy:60,
                     bx:{8'd150, 8'd0, 8'd0, 8'd0}, by:{7'd60, 7'd0, 7'd0, 7'd0},
                     ax:150, ay:110, chk_next:0, nx:0, ny:0,
                     shift:0, grow:0, eaten:0, dead:1, lat:2, dir:0};
`endif

        reset = 1'b1; step = 1'b0; key_n = 4'hF;
        drive(vecs[0]);
        do_reset();
        @(negedge clk);
        chk("rst_dir", int'(dir), 2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dead", int'(dead), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_next_x", int'(next_x), 0);
        chk("rst_next_y", int'(next_y), 0);
        chk("rst_seg_idx", int'(seg_idx), 0);

        for (int i = 0; i <= 10; i++) run_vec(i, vecs[i]);

        // dead is sticky and further steps are ignored
        n_busy = 0; n_done = 0; n_pulse = 0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_busy  += int'(busy);
            n_done  += int'(done);
            n_pulse += int'(shift_en) + int'(grow) + int'(eaten);
            chk("dead_sticky", int'(dead), 1);
            @(negedge clk);
        end
        chk("dead_step_busy", n_busy, 0);
        chk("dead_step_done", n_done, 0);
        chk("dead_step_pulses", n_pulse, 0);

        for (int i = 11; i <= 12; i++) run_vec(i, vecs[i]);

        // reset in the middle of a scan
        do_reset();
        v = vecs[0];
        drive(v);
        key_n = 4'b0111;
        @(negedge clk);
        key_n = 4'hF;
        step  = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        chk("mid_scan_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_dir", int'(dir), 2);
        chk("abort_next_x", int'(next_x), 0);
        n_done = 0; n_pulse = 0;
        for (int c = 0; c < 6; c++) begin
            n_done  += int'(done) + int'(busy);
            n_pulse += int'(shift_en) + int'(grow) + int'(eaten) + int'(dead);
            @(negedge clk);
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_no_pulse", n_pulse, 0);
        v.rst = 0;
        run_vec(13, v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
